// File: rtl/input_debouncer_if.sv
// Signal bundle for the input debouncer: raw level in, debounced level and
// qualification status out. The master side drives the raw input; the slave
// side is the debouncer itself.
interface input_debouncer_if;
  logic in;
  logic out;
  logic rise;
  logic fall;
  logic busy;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall,
    input  busy
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall,
    output busy
  );
endinterface

// File: rtl/input_debouncer.sv
// Input debouncer: synchronizes a raw asynchronous bit through a flop chain,
// then only lets a level change through to `out` after the synchronized value
// has disagreed with `out` for STABLE_CYCLES consecutive clocks.
// Optional macro INPUT_DEBOUNCER_EDGE_EN builds the rise/fall strobe
// registers; without it both strobes are tied low.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input logic         clk,
  input logic         reset,
  input_debouncer_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {
    StIdleLo = 2'd0,
    StChkHi  = 2'd1,
    StIdleHi = 2'd2,
    StChkLo  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   out_q;

  // Synchronizer chain; the raw input is only ever seen by stage 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef INPUT_DEBOUNCER_EDGE_EN
  logic rise_q;
  logic fall_q;
`endif

  // Qualification FSM with registered level and strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdleLo;
      cnt_q   <= '0;
      out_q   <= 1'b0;
`ifdef INPUT_DEBOUNCER_EDGE_EN
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`endif
    end else begin
`ifdef INPUT_DEBOUNCER_EDGE_EN
      rise_q <= 1'b0;
      fall_q <= 1'b0;
`endif
      unique case (state_q)
        StIdleLo, StIdleHi: begin
          if (s == out_q) begin
            cnt_q <= '0;
          end else if (STABLE_CYCLES == 1) begin
            // Single-cycle qualification: toggle straight to the other idle.
            out_q   <= ~out_q;
            state_q <= out_q ? StIdleLo : StIdleHi;
            cnt_q   <= '0;
`ifdef INPUT_DEBOUNCER_EDGE_EN
            rise_q  <= ~out_q;
            fall_q  <= out_q;
`endif
          end else begin
            state_q <= out_q ? StChkLo : StChkHi;
            cnt_q   <= CntOne;
          end
        end
        StChkHi, StChkLo: begin
          if (s == out_q) begin
            // Glitch: discard the partial count, level unchanged.
            state_q <= out_q ? StIdleHi : StIdleLo;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            out_q   <= ~out_q;
            state_q <= out_q ? StIdleLo : StIdleHi;
            cnt_q   <= '0;
`ifdef INPUT_DEBOUNCER_EDGE_EN
            rise_q  <= ~out_q;
            fall_q  <= out_q;
`endif
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StIdleLo;
          cnt_q   <= '0;
          out_q   <= 1'b0;
        end
      endcase
    end
  end

  // Output drive: busy is a pure decode of the registered state.
  assign bus.out  = out_q;
  assign bus.busy = (state_q == StChkHi) || (state_q == StChkLo);
`ifdef INPUT_DEBOUNCER_EDGE_EN
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
`else
  assign bus.rise = 1'b0;
  assign bus.fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with default parameters.
module tb_input_debouncer;

  localparam int SyncStages   = 2;
  localparam int StableCycles = 16;
  localparam bit EdgeEn =
`ifdef INPUT_DEBOUNCER_EDGE_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  input_debouncer_if dbg ();

  input_debouncer #(
    .SYNC_STAGES  (SyncStages),
    .STABLE_CYCLES(StableCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dbg)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a delay line for the synchronizer and a run-length of
  // consecutive disagreements between the synchronized value and out.
  bit m_line[$];
  bit m_out;
  int m_run;
  bit m_rise;
  bit m_fall;

  task automatic model_reset();
    m_line.delete();
    for (int i = 0; i < SyncStages; i++) m_line.push_back(1'b0);
    m_out  = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  task automatic model_edge(input bit din);
    bit s_pre;
    s_pre = m_line[0];
    void'(m_line.pop_front());
    m_line.push_back(din);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (s_pre != m_out) begin
      m_run++;
      if (m_run == StableCycles) begin
        m_out  = ~m_out;
        m_rise = EdgeEn & m_out;
        m_fall = EdgeEn & ~m_out;
        m_run  = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},  dbg.out,  m_out);
    check({tag, ".busy"}, dbg.busy, m_run != 0);
    check({tag, ".rise"}, dbg.rise, m_rise);
    check({tag, ".fall"}, dbg.fall, m_fall);
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(dbg.in);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    bit din;
    int ncyc;
    bit e_out;
    bit e_busy;
    int e_rise;
    int e_fall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int rcnt;
    int fcnt;
    int n;
    bit lvl;
    int len;

    // din, cycles, out at end, busy at end, rise count, fall count
    vecs[0] = '{1'b0, 50, 1'b0, 1'b0, 0, 0};  // idle low stays quiet
    vecs[1] = '{1'b1, 17, 1'b0, 1'b1, 0, 0};  // qualifying, not yet toggled
    vecs[2] = '{1'b1,  1, 1'b1, 1'b0, 1, 0};  // edge 18: out rises
    vecs[3] = '{1'b1, 10, 1'b1, 1'b0, 0, 0};
    vecs[4] = '{1'b0, 10, 1'b1, 1'b1, 0, 0};  // 10-cycle low pulse begins
    vecs[5] = '{1'b1,  5, 1'b1, 1'b0, 0, 0};  // pulse rejected, busy drops
    vecs[6] = '{1'b0, 18, 1'b0, 1'b0, 0, 1};  // held low: out falls
    vecs[7] = '{1'b1, 15, 1'b0, 1'b1, 0, 0};  // 15-cycle high pulse
    vecs[8] = '{1'b0, 20, 1'b0, 1'b0, 0, 0};  // rejected

    dbg.in = 1'b0;
    reset  = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;

    foreach (vecs[k]) begin
      dbg.in = vecs[k].din;
      rcnt = 0;
      fcnt = 0;
      repeat (vecs[k].ncyc) begin
        tick($sformatf("vec%0d", k));
        rcnt += int'(dbg.rise);
        fcnt += int'(dbg.fall);
      end
      check($sformatf("vec%0d.end_out", k),  dbg.out,  vecs[k].e_out);
      check($sformatf("vec%0d.end_busy", k), dbg.busy, vecs[k].e_busy);
      check($sformatf("vec%0d.nrise", k), rcnt == (EdgeEn ? vecs[k].e_rise : 0), 1'b1);
      check($sformatf("vec%0d.nfall", k), fcnt == (EdgeEn ? vecs[k].e_fall : 0), 1'b1);
    end

    // Reset mid-qualification: 12 edges with in=1 leaves the count at 10.
    dbg.in = 1'b1;
    repeat (12) tick("preq");
    check("preq.busy", dbg.busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("arst.out",  dbg.out,  1'b0);
    check("arst.busy", dbg.busy, 1'b0);
    check("arst.rise", dbg.rise, 1'b0);
    check("arst.fall", dbg.fall, 1'b0);
    model_reset();
    #2 reset = 1'b0;
    n = 0;
    while (dbg.out !== 1'b1 && n < 40) begin
      tick("post_rst");
      n++;
    end
    check("post_rst.latency18", n == SyncStages + StableCycles, 1'b1);
    check("post_rst.rise", dbg.rise, EdgeEn);

    // Random run lengths around the qualification threshold.
    lvl = 1'b1;
    for (int r = 0; r < 200; r++) begin
      lvl = ~lvl;
      dbg.in = lvl;
      len = $urandom_range(1, 24);
      repeat (len) tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
